// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment scan scheduler.
package seg_pkg;

    localparam int NUM_DIGITS   = 4;
    localparam int BRIGHT_STEPS = 16;
    localparam int NIBBLE_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2,
        ST_OFF   = 2'd3
    } state_t;

    function automatic logic [NUM_DIGITS-1:0] onehot(input logic [1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/seg_next_digit.sv
// Finds the next enabled digit above cur, wrapping to the lowest enabled one.
module seg_next_digit
    import seg_pkg::*;
(
    input  logic [1:0]            cur,
    input  logic [NUM_DIGITS-1:0] mask,
    output logic [1:0]            nxt,
    output logic                  wrap
);

    always_comb begin
        nxt  = 2'd0;
        wrap = 1'b1;
        // Descending scans leave the lowest qualifying index in nxt.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) nxt = 2'(i);
        end
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt  = 2'(i);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_scheduler.sv
// Multiplexed 4-digit display scan: blanking, per-slot PWM brightness,
// and a double-buffered display value committed at frame boundaries.
module seg_scan_scheduler
    import seg_pkg::*;
#(
    parameter int BLANK = 2,
    parameter int STEP  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [NUM_DIGITS-1:0] i_digitMask,
    input  logic [3:0]            i_bright,
    input  logic [15:0]           i_data,
    input  logic                  i_load,
    output logic                  o_loadAck,
    output logic [1:0]            o_ctrl,
    output logic [NUM_DIGITS-1:0] o_digitSelect,
    output logic [NIBBLE_W-1:0]   o_nibble,
    output logic                  o_frame,
    output state_t                state_dbg
);

    localparam int SLOT_LEN = BLANK + BRIGHT_STEPS * STEP;
    localparam int CW       = $clog2(SLOT_LEN);
    localparam int SW       = (STEP > 1) ? $clog2(STEP) : 1;
    localparam logic [CW-1:0] BLANK_LAST  = CW'(BLANK - 1);
    localparam logic [CW-1:0] SLOT_PENULT = CW'(SLOT_LEN - 2);
    localparam logic [CW-1:0] SLOT_LAST   = CW'(SLOT_LEN - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(STEP - 1);

    state_t                state, state_n;
    logic [CW-1:0]         slot_cnt, slot_n;
    logic [3:0]            step_idx, step_n;
    logic [SW-1:0]         sub_cnt, sub_n;
    logic [3:0]            bright_q, bright_n;
    logic [1:0]            nxt_q, nxt_n, ctrl_n, search_cur, nd_idx;
    logic                  mask_zero_q, mask_zero_n, nd_wrap, frame_n;
    logic                  ack_d, load_req, commit;
    logic [15:0]           shadow, shadow_n;
    logic [NUM_DIGITS-1:0] sel_n;
    logic [NIBBLE_W-1:0]   nib_n;

    // From IDLE, searching "above 3" yields the lowest enabled digit.
    assign search_cur = (state == ST_IDLE) ? 2'd3 : o_ctrl;
    assign state_dbg  = state;

    seg_next_digit u_next (
        .cur  (search_cur),
        .mask (i_digitMask),
        .nxt  (nd_idx),
        .wrap (nd_wrap)
    );

    // Load handshake: i_load is a level request; the shadow takes i_data in
    // the commit cycle and o_loadAck pulses once the cycle after. i_load is
    // ignored during the ack cycle and the one after, so a level still high
    // beyond that is a fresh request.
    always_comb begin
        state_n     = state;
        slot_n      = slot_cnt;
        step_n      = step_idx;
        sub_n       = sub_cnt;
        bright_n    = bright_q;
        nxt_n       = nxt_q;
        mask_zero_n = mask_zero_q;
        ctrl_n      = o_ctrl;
        frame_n     = 1'b0;
        load_req    = i_load & ~o_loadAck & ~ack_d;
        commit      = load_req & ((state == ST_IDLE) | o_frame);
        shadow_n    = commit ? i_data : shadow;

        case (state)
            ST_IDLE: begin
                if (i_en && (i_digitMask != '0)) begin
                    state_n = ST_BLANK;
                    ctrl_n  = nd_idx;
                    slot_n  = '0;
                end
            end
            default: begin
                slot_n = slot_cnt + CW'(1);
                if (state == ST_BLANK) begin
                    if (slot_cnt == BLANK_LAST) begin
                        bright_n = i_bright;
                        state_n  = (i_bright != 4'd0) ? ST_ON : ST_OFF;
                        step_n   = '0;
                        sub_n    = '0;
                    end
                end else if (sub_cnt == STEP_LAST) begin
                    sub_n  = '0;
                    step_n = step_idx + 4'd1;
                    if (state == ST_ON && ({1'b0, step_idx} + 5'd1) == {1'b0, bright_q})
                        state_n = ST_OFF;
                end else begin
                    sub_n = sub_cnt + SW'(1);
                end
                // The next digit is resolved one cycle early so that the
                // registered o_frame lands on the last cycle of the slot.
                if (slot_cnt == SLOT_PENULT) begin
                    nxt_n       = nd_idx;
                    mask_zero_n = (i_digitMask == '0);
                    frame_n     = nd_wrap | (i_digitMask == onehot(o_ctrl));
                end
                if (slot_cnt == SLOT_LAST) begin
                    slot_n  = '0;
                    ctrl_n  = nxt_q;
                    state_n = mask_zero_q ? ST_IDLE : ST_BLANK;
                end
                if (!i_en) begin
                    state_n = ST_IDLE;
                    slot_n  = '0;
                    ctrl_n  = o_ctrl;
                    frame_n = 1'b0;
                end
            end
        endcase

        sel_n = (state_n == ST_ON) ? onehot(ctrl_n) : '0;
        nib_n = shadow_n[{ctrl_n, 2'b00} +: NIBBLE_W];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= ST_IDLE;
            slot_cnt      <= '0;
            step_idx      <= '0;
            sub_cnt       <= '0;
            bright_q      <= '0;
            nxt_q         <= '0;
            mask_zero_q   <= 1'b0;
            ack_d         <= 1'b0;
            shadow        <= '0;
            o_ctrl        <= '0;
            o_digitSelect <= '0;
            o_nibble      <= '0;
            o_frame       <= 1'b0;
            o_loadAck     <= 1'b0;
        end else begin
            state         <= state_n;
            slot_cnt      <= slot_n;
            step_idx      <= step_n;
            sub_cnt       <= sub_n;
            bright_q      <= bright_n;
            nxt_q         <= nxt_n;
            mask_zero_q   <= mask_zero_n;
            ack_d         <= o_loadAck;
            shadow        <= shadow_n;
            o_ctrl        <= ctrl_n;
            o_digitSelect <= sel_n;
            o_nibble      <= nib_n;
            o_frame       <= frame_n;
            o_loadAck     <= commit;
        end
    end

endmodule
